// File: rtl/updown_counter_ctrl.sv
// Up/down counter with programmable bounds, per-cycle step, wrap/saturate/one-shot modes
// and sticky overflow/underflow flags. Define UDC_PRESCALER_EN to gate steps through a modulo-PRESCALE divider.
module updown_counter_ctrl #(
    parameter int WIDTH    = 4,
    parameter int MIN_VAL  = 0,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter int STEP_W   = 2,
    parameter int PRESCALE = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              UpDown,
    input  logic              LoadCount,
    input  logic [WIDTH-1:0]  CounterLoad,
    input  logic [STEP_W-1:0] Step,
    input  logic [1:0]        Mode,
    input  logic              ClearFlags,
    output logic [WIDTH-1:0]  CounterOutput,
    output logic              TerminalCount,
    output logic              Overflow,
    output logic              Underflow,
    output logic              Running
);

    // One guard bit plus sign bit keeps count +/- Step exact.
    localparam int AW = WIDTH + STEP_W + 1;
    localparam int RANGE = MAX_VAL - MIN_VAL + 1;
    localparam logic signed [AW-1:0] MIN_S   = AW'(MIN_VAL);
    localparam logic signed [AW-1:0] MAX_S   = AW'(MAX_VAL);
    localparam logic signed [AW-1:0] RANGE_S = AW'(RANGE);
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [1:0] MODE_SAT = 2'd1;
    localparam logic [1:0] MODE_ONE = 2'd2;

    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    state_t state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic tc_q, tc_d, ovf_q, ovf_d, unf_q, unf_d;
    logic presc_tick, step_take, halt_hit;
    logic signed [AW-1:0] count_ext, step_ext, load_ext, raw_up, raw_dn;

    assign count_ext = signed'({{(AW-WIDTH){1'b0}}, count_q});
    assign step_ext  = signed'({{(AW-STEP_W){1'b0}}, Step});
    assign load_ext  = signed'({{(AW-WIDTH){1'b0}}, CounterLoad});
    assign raw_up    = count_ext + step_ext;
    assign raw_dn    = count_ext - step_ext;

`ifdef UDC_PRESCALER_EN
    localparam int PW = $clog2(PRESCALE);
    logic [PW-1:0] presc_q, presc_d;

    assign presc_tick = (presc_q == PW'(PRESCALE-1));

    // Divider restarts on load and whenever the counter drops into HALT.
    always_comb begin
        presc_d = presc_q;
        if (LoadCount || (state_q == ST_RUN && state_d == ST_HALT))
            presc_d = '0;
        else if (Enable && state_q == ST_RUN)
            presc_d = presc_tick ? '0 : presc_q + PW'(1);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) presc_q <= '0;
        else       presc_q <= presc_d;
    end
`else
    assign presc_tick = 1'b1;
`endif

    assign step_take = Enable && !LoadCount && (state_q == ST_RUN) && presc_tick && (Step != '0);

    always_comb begin
        count_d  = count_q;
        tc_d     = 1'b0;
        ovf_d    = ovf_q & ~ClearFlags;
        unf_d    = unf_q & ~ClearFlags;
        halt_hit = 1'b0;
        if (LoadCount) begin
            if (load_ext < MIN_S)      count_d = MIN_W;
            else if (load_ext > MAX_S) count_d = MAX_W;
            else                       count_d = CounterLoad;
        end else if (step_take) begin
            if (UpDown) begin
                if (raw_up > MAX_S) begin
                    ovf_d = 1'b1;
                    tc_d  = 1'b1;
                    case (Mode)
                        MODE_SAT: count_d = MAX_W;
                        MODE_ONE: begin
                            count_d  = MAX_W;
                            halt_hit = 1'b1;
                        end
                        default:  count_d = WIDTH'(raw_up - RANGE_S);
                    endcase
                end else begin
                    count_d = raw_up[WIDTH-1:0];
                    if (raw_up == MAX_S) begin
                        tc_d     = 1'b1;
                        halt_hit = (Mode == MODE_ONE);
                    end
                end
            end else begin
                if (raw_dn < MIN_S) begin
                    unf_d = 1'b1;
                    tc_d  = 1'b1;
                    case (Mode)
                        MODE_SAT: count_d = MIN_W;
                        MODE_ONE: begin
                            count_d  = MIN_W;
                            halt_hit = 1'b1;
                        end
                        default:  count_d = WIDTH'(raw_dn + RANGE_S);
                    endcase
                end else begin
                    count_d = raw_dn[WIDTH-1:0];
                    if (raw_dn == MIN_S) begin
                        tc_d     = 1'b1;
                        halt_hit = (Mode == MODE_ONE);
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (halt_hit) state_d = ST_HALT;
            default: if (LoadCount || Mode != MODE_ONE) state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_RUN;
            count_q <= MIN_W;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_comb begin
        Running       = (state_q == ST_RUN);
        CounterOutput = count_q;
        TerminalCount = tc_q;
        Overflow      = ovf_q;
        Underflow     = unf_q;
    end

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Bench for updown_counter_ctrl (WIDTH=4, MIN_VAL=2, MAX_VAL=12, STEP_W=2, PRESCALE=4):
// vector table, hand-written corner sequences and random stimulus against a reference model.
module tb_updown_counter_ctrl;

    localparam int W = 4, MINV = 2, MAXV = 12, SW = 2, PS = 4;
    localparam int RNG = MAXV - MINV + 1;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          Enable = 1'b0, UpDown = 1'b0, LoadCount = 1'b0, ClearFlags = 1'b0;
    logic [W-1:0]  CounterLoad = '0;
    logic [SW-1:0] Step = '0;
    logic [1:0]    Mode = '0;
    logic [W-1:0]  CounterOutput;
    logic          TerminalCount, Overflow, Underflow, Running;

    updown_counter_ctrl #(
        .WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV), .STEP_W(SW), .PRESCALE(PS)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .UpDown(UpDown),
        .LoadCount(LoadCount), .CounterLoad(CounterLoad), .Step(Step), .Mode(Mode),
        .ClearFlags(ClearFlags), .CounterOutput(CounterOutput),
        .TerminalCount(TerminalCount), .Overflow(Overflow), .Underflow(Underflow),
        .Running(Running)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       ld;
        int         lv;
        logic       en;
        logic       up;
        int         st;
        int         md;
        logic       clr;
        int         c;
        int         tc;
        int         ov;
        int         un;
        int         run;
    } vec_t;

    vec_t tbl[16];

    // Reference model state
    int m_cnt, m_tc, m_ov, m_un, m_run, m_ps;

    function automatic vec_t mk(input int ld, lv, en, up, st, md, clr, c, tc, ov, un, run);
        vec_t v;
        v.ld = ld[0]; v.lv = lv; v.en = en[0]; v.up = up[0]; v.st = st; v.md = md; v.clr = clr[0];
        v.c = c; v.tc = tc; v.ov = ov; v.un = un; v.run = run;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        total++;
        if (act !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int c, tc, ov, un, run);
        chk({tag, ".count"}, 32'(CounterOutput), c);
        chk({tag, ".tc"},    32'(TerminalCount), tc);
        chk({tag, ".ovf"},   32'(Overflow), ov);
        chk({tag, ".unf"},   32'(Underflow), un);
        chk({tag, ".run"},   32'(Running), run);
    endtask

    task automatic drive(input int ld, lv, en, up, st, md, clr);
        LoadCount = ld[0]; CounterLoad = W'(lv); Enable = en[0]; UpDown = up[0];
        Step = SW'(st); Mode = md[1:0]; ClearFlags = clr[0];
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic model_reset();
        m_cnt = MINV; m_tc = 0; m_ov = 0; m_un = 0; m_run = 1; m_ps = 0;
    endtask

    // One clock of behaviour, computed from the rules with plain integer arithmetic.
    task automatic model_step(input int ld, lv, en, up, st, md, clr);
        int raw;
        bit take;
        m_tc = 0;
        if (clr != 0) begin m_ov = 0; m_un = 0; end
        if (ld != 0) begin
            m_cnt = (lv < MINV) ? MINV : (lv > MAXV) ? MAXV : lv;
            m_run = 1;
            m_ps = 0;
        end else if (m_run == 0) begin
            if (md != 2) m_run = 1;
        end else if (en != 0) begin
            take = 1;
`ifdef UDC_PRESCALER_EN
            m_ps++;
            if (m_ps == PS) m_ps = 0;
            else take = 0;
`endif
            if (take && st != 0) begin
                raw = (up != 0) ? m_cnt + st : m_cnt - st;
                if ((up != 0 && raw >= MAXV) || (up == 0 && raw <= MINV)) m_tc = 1;
                if (up != 0 && raw > MAXV) m_ov = 1;
                if (up == 0 && raw < MINV) m_un = 1;
                if (m_tc == 1 && md == 2) begin
                    m_cnt = (up != 0) ? MAXV : MINV;
                    m_run = 0;
                    m_ps = 0;
                end else if (md == 1 && (raw > MAXV || raw < MINV)) begin
                    m_cnt = (up != 0) ? MAXV : MINV;
                end else begin
                    m_cnt = MINV + (((raw - MINV) % RNG) + RNG) % RNG;
                end
            end
        end
    endtask

    initial begin
        int ld, lv, en, up, st, md, clr;

        tbl[0]  = mk(1, 11, 0, 1, 0, 0, 0,  11, 0, 0, 0, 1);
        tbl[1]  = mk(0,  0, 1, 1, 3, 0, 0,   3, 1, 1, 0, 1);
        tbl[2]  = mk(0,  0, 0, 1, 3, 0, 0,   3, 0, 1, 0, 1);
        tbl[3]  = mk(0,  0, 0, 0, 0, 0, 1,   3, 0, 0, 0, 1);
        tbl[4]  = mk(1,  4, 0, 0, 0, 1, 0,   4, 0, 0, 0, 1);
        tbl[5]  = mk(0,  0, 1, 0, 2, 1, 0,   2, 1, 0, 0, 1);
        tbl[6]  = mk(0,  0, 1, 0, 2, 1, 0,   2, 1, 0, 1, 1);
        tbl[7]  = mk(0,  0, 0, 0, 0, 1, 1,   2, 0, 0, 0, 1);
        tbl[8]  = mk(1, 15, 1, 1, 3, 0, 0,  12, 0, 0, 0, 1);
        tbl[9]  = mk(0,  0, 1, 1, 1, 0, 1,   2, 1, 1, 0, 1);
        tbl[10] = mk(0,  0, 0, 0, 0, 0, 1,   2, 0, 0, 0, 1);
        tbl[11] = mk(0,  0, 1, 1, 0, 0, 0,   2, 0, 0, 0, 1);
        tbl[12] = mk(0,  0, 1, 0, 1, 3, 0,  12, 1, 0, 1, 1);
        tbl[13] = mk(0,  0, 0, 0, 0, 0, 1,  12, 0, 0, 0, 1);
        tbl[14] = mk(1,  0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 1);
        tbl[15] = mk(0,  0, 1, 1, 3, 1, 0,   5, 0, 0, 0, 1);

        // Reset state
        repeat (2) @(posedge Clock);
        #1;
        check_outs("reset", MINV, 0, 0, 0, 1);
        $display("reset: cnt=%0d run=%0b", CounterOutput, Running);
        Reset = 1'b0;

`ifndef UDC_PRESCALER_EN
        // Asynchronous reset mid-count at 9, observed before any clock edge
        drive(1, 8, 0, 1, 0, 0, 0); cyc();
        drive(0, 0, 1, 1, 1, 0, 0); cyc();
        chk("pre_reset.count", 32'(CounterOutput), 9);
        drive(0, 0, 0, 1, 0, 0, 0);
        #2 Reset = 1'b1;
        #1;
        check_outs("async_reset", MINV, 0, 0, 0, 1);
        $display("async reset: cnt=%0d", CounterOutput);
        Reset = 1'b0;
        drive(0, 0, 1, 1, 1, 0, 0); cyc();
        chk("post_reset_step.count", 32'(CounterOutput), 3);
        $display("post-reset step: cnt=%0d", CounterOutput);

        for (int i = 0; i < 16; i++) begin
            drive(int'(tbl[i].ld), tbl[i].lv, int'(tbl[i].en), int'(tbl[i].up),
                  tbl[i].st, tbl[i].md, int'(tbl[i].clr));
            cyc();
            check_outs($sformatf("vec%0d", i), tbl[i].c, tbl[i].tc, tbl[i].ov, tbl[i].un, tbl[i].run);
            $display("vec %0d: cnt=%0d tc=%0b ovf=%0b unf=%0b run=%0b",
                     i, CounterOutput, TerminalCount, Overflow, Underflow, Running);
        end

        // One-shot: reach MAX, halt, hold with Enable held, then reload
        drive(1, 10, 0, 1, 1, 2, 0); cyc();
        drive(0, 0, 1, 1, 1, 2, 0); cyc();
        check_outs("oneshot1", 11, 0, 0, 0, 1);
        cyc();
        check_outs("oneshot2", 12, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check_outs($sformatf("halt%0d", i), 12, 0, 0, 0, 0);
            $display("halt hold %0d: cnt=%0d run=%0b", i, CounterOutput, Running);
        end
        drive(1, 5, 1, 1, 1, 2, 0); cyc();
        check_outs("reload", 5, 0, 0, 0, 1);
        // Leave HALT via a mode change: one idle edge, then normal counting
        drive(1, 11, 0, 1, 1, 2, 0); cyc();
        drive(0, 0, 1, 1, 1, 2, 0); cyc();
        check_outs("oneshot3", 12, 1, 0, 0, 0);
        drive(0, 0, 1, 1, 1, 0, 0); cyc();
        check_outs("mode_exit", 12, 0, 0, 0, 1);
        cyc();
        check_outs("mode_exit_step", 2, 1, 1, 0, 1);
        $display("mode exit: cnt=%0d ovf=%0b", CounterOutput, Overflow);
        drive(0, 0, 0, 1, 0, 0, 1); cyc();
`else
        // Prescaled counting: a step on every 4th enabled cycle
        drive(0, 0, 1, 1, 1, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            cyc();
            chk($sformatf("presc%0d.count", i), 32'(CounterOutput), MINV + i / PS);
            chk($sformatf("presc%0d.tc", i), 32'(TerminalCount), 0);
            $display("presc cycle %0d: cnt=%0d", i, CounterOutput);
        end
        cyc(); cyc();
        chk("presc_mid.count", 32'(CounterOutput), 5);
        drive(1, 7, 1, 1, 1, 0, 0); cyc();
        chk("presc_load.count", 32'(CounterOutput), 7);
        drive(0, 0, 1, 1, 1, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk($sformatf("presc_restart%0d.count", i), 32'(CounterOutput), (i == 4) ? 8 : 7);
            $display("presc restart %0d: cnt=%0d", i, CounterOutput);
        end
`endif

        // Random stimulus against the reference model
        drive(0, 0, 0, 0, 0, 0, 0);
        Reset = 1'b1;
        #2 Reset = 1'b0;
        model_reset();
        md = 0;
        for (int i = 0; i < 400; i++) begin
            ld  = (($urandom % 10) == 0) ? 1 : 0;
            lv  = int'($urandom % 16);
            en  = (($urandom % 4) != 0) ? 1 : 0;
            up  = int'($urandom % 2);
            st  = int'($urandom % 4);
            if (($urandom % 8) == 0) md = int'($urandom % 4);
            clr = (($urandom % 8) == 0) ? 1 : 0;
            drive(ld, lv, en, up, st, md, clr);
            @(posedge Clock);
            model_step(ld, lv, en, up, st, md, clr);
            #1;
            check_outs($sformatf("rand%0d", i), m_cnt, m_tc, m_ov, m_un, m_run);
            $display("rand %0d: ld=%0d en=%0d up=%0d st=%0d md=%0d -> cnt=%0d model=%0d",
                     i, ld, en, up, st, md, CounterOutput, m_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
